// File: rtl/fft_st_framer.sv
// rtl/fft_st_framer.sv - Avalon-ST framer feeding the FFT core plus peak-bin analyser on its output
//
// Source path: registers input samples into FFT packets of 2^clamp(cfg_log2_n) beats,
//   with SOP/EOP and {real, imag, fftpts, inverse} packed into src_data.
// Sink path: checks framing of the FFT output stream and publishes, once per frame,
//   the bin with the largest |re|+|im| together with the frame exponent and an error flag.
// Ports:
//   clk_clk, reset_reset_n                       clock, asynchronous active-low reset
//   cfg_log2_n, cfg_inverse, cfg_clear           run-time configuration, sticky clear pulse
//   in_valid/in_ready/in_real/in_imag            sample input stream
//   src_valid/src_ready/src_sop/src_eop/
//   src_error/src_data                           stream towards the FFT core
//   snk_valid/snk_ready/snk_sop/snk_eop/
//   snk_error/snk_data                           stream from the FFT core
//   result_valid/bin/mag/exp/err                 per-frame peak report
//   err_sticky                                   any error since last clear
module fft_st_framer #(
    parameter int DATA_W     = 16,
    parameter int LOG2_N_MAX = 10,
    parameter int EXP_W      = 6
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    input  logic [3:0]                     cfg_log2_n,
    input  logic                           cfg_inverse,
    input  logic                           cfg_clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_real,
    input  logic [DATA_W-1:0]              in_imag,
    output logic                           src_valid,
    input  logic                           src_ready,
    output logic                           src_sop,
    output logic                           src_eop,
    output logic [1:0]                     src_error,
    output logic [2*DATA_W+LOG2_N_MAX+1:0] src_data,
    input  logic                           snk_valid,
    output logic                           snk_ready,
    input  logic                           snk_sop,
    input  logic                           snk_eop,
    input  logic [1:0]                     snk_error,
    input  logic [2*DATA_W+EXP_W-1:0]      snk_data,
    output logic                           result_valid,
    output logic [LOG2_N_MAX-1:0]          result_bin,
    output logic [DATA_W:0]                result_mag,
    output logic [EXP_W-1:0]               result_exp,
    output logic                           result_err,
    output logic                           err_sticky
);

    localparam logic [0:0] WAIT_SOP = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;

    localparam logic [LOG2_N_MAX-1:0] IDX_ONE = 1;
    localparam logic [LOG2_N_MAX:0]   PTS_ONE = 1;

    function automatic logic [3:0] clamp_log2(input logic [3:0] c);
        if (c < 4'd3) return 4'd3;
        if (int'(c) > LOG2_N_MAX) return 4'(LOG2_N_MAX);
        return c;
    endfunction

    // Index of the last beat of a 2^k frame, i.e. 2^k - 1.
    function automatic logic [LOG2_N_MAX-1:0] last_index(input logic [3:0] k);
        logic [LOG2_N_MAX-1:0] r;
        for (int i = 0; i < LOG2_N_MAX; i++) r[i] = (i < int'(k));
        return r;
    endfunction

    // One extra bit so that |-2^(DATA_W-1)| is representable.
    function automatic logic [DATA_W:0] abs_ext(input logic [DATA_W-1:0] x);
        logic [DATA_W:0] xe;
        xe = {x[DATA_W-1], x};
        return xe[DATA_W] ? -xe : xe;
    endfunction

    // ---------------- source path ----------------
    logic [LOG2_N_MAX-1:0] sidx;
    logic [LOG2_N_MAX-1:0] src_last;
    logic                  src_inv;
    logic [LOG2_N_MAX-1:0] cur_last;
    logic                  cur_inv;
    logic                  accept;

    assign in_ready  = !src_valid || src_ready;
    assign accept    = in_valid && in_ready;
    assign src_error = 2'b00;

    // Frame size and direction are taken live on the first beat, then held for the frame.
    always_comb begin
        cur_last = src_last;
        cur_inv  = src_inv;
        if (sidx == '0) begin
            cur_last = last_index(clamp_log2(cfg_log2_n));
            cur_inv  = cfg_inverse;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
            src_data  <= '0;
            src_last  <= '0;
            src_inv   <= 1'b0;
            sidx      <= '0;
        end else if (accept) begin
            src_valid <= 1'b1;
            src_sop   <= (sidx == '0);
            src_eop   <= (sidx == cur_last);
            src_data  <= {in_real, in_imag, {1'b0, cur_last} + PTS_ONE, cur_inv};
            src_last  <= cur_last;
            src_inv   <= cur_inv;
            sidx      <= (sidx == cur_last) ? '0 : sidx + IDX_ONE;
        end else if (src_ready) begin
            src_valid <= 1'b0;
        end
    end

    // ---------------- sink path ----------------
    logic [0:0]            state;
    logic [LOG2_N_MAX-1:0] sidx_snk;
    logic [LOG2_N_MAX-1:0] snk_last;
    logic [LOG2_N_MAX-1:0] peak_bin;
    logic [DATA_W:0]       peak_mag;
    logic [EXP_W-1:0]      exp_q;
    logic                  frame_err;

    logic [DATA_W-1:0]     beat_re;
    logic [DATA_W-1:0]     beat_im;
    logic [EXP_W-1:0]      beat_exp;
    logic [DATA_W:0]       mag;
    logic                  last_beat;
    logic                  mag_gt;
    logic                  beat_err;
    logic                  pub;
    logic [LOG2_N_MAX-1:0] pub_bin;
    logic [DATA_W:0]       pub_mag;
    logic [EXP_W-1:0]      pub_exp;
    logic                  pub_err;
    logic                  drop;

    assign snk_ready = 1'b1;
    assign beat_re   = snk_data[2*DATA_W+EXP_W-1 -: DATA_W];
    assign beat_im   = snk_data[DATA_W+EXP_W-1 -: DATA_W];
    assign beat_exp  = snk_data[EXP_W-1:0];
    assign mag       = abs_ext(beat_re) + abs_ext(beat_im);

    always_comb begin
        last_beat = (sidx_snk == snk_last);
        mag_gt    = (mag > peak_mag);
        beat_err  = frame_err | (|snk_error) | (snk_eop != last_beat);
        pub       = 1'b0;
        pub_bin   = peak_bin;
        pub_mag   = peak_mag;
        pub_exp   = exp_q;
        pub_err   = 1'b1;
        drop      = 1'b0;
        if (snk_valid) begin
            if (state == WAIT_SOP) begin
                drop = !snk_sop;
            end else if (snk_sop) begin
                // Unexpected SOP: the frame in progress is cut short and reported as bad.
                pub = 1'b1;
            end else if (snk_eop || last_beat) begin
                pub     = 1'b1;
                pub_bin = mag_gt ? sidx_snk : peak_bin;
                pub_mag = mag_gt ? mag : peak_mag;
                pub_exp = beat_exp;
                pub_err = beat_err;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= WAIT_SOP;
            sidx_snk  <= '0;
            snk_last  <= '0;
            peak_bin  <= '0;
            peak_mag  <= '0;
            exp_q     <= '0;
            frame_err <= 1'b0;
        end else if (snk_valid) begin
            if (snk_sop) begin
                state     <= IN_FRAME;
                snk_last  <= last_index(clamp_log2(cfg_log2_n));
                sidx_snk  <= IDX_ONE;
                peak_bin  <= '0;
                peak_mag  <= mag;
                exp_q     <= beat_exp;
                frame_err <= (|snk_error) | snk_eop;
            end else if (state == IN_FRAME) begin
                if (mag_gt) begin
                    peak_bin <= sidx_snk;
                    peak_mag <= mag;
                end
                exp_q     <= beat_exp;
                frame_err <= beat_err;
                if (snk_eop || last_beat) begin
                    state    <= WAIT_SOP;
                    sidx_snk <= '0;
                end else begin
                    sidx_snk <= sidx_snk + IDX_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            result_valid <= 1'b0;
            result_bin   <= '0;
            result_mag   <= '0;
            result_exp   <= '0;
            result_err   <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            result_valid <= pub;
            if (pub) begin
                result_bin <= pub_bin;
                result_mag <= pub_mag;
                result_exp <= pub_exp;
                result_err <= pub_err;
            end
            // A new error takes priority over a simultaneous clear.
            if (drop || (pub && pub_err)) begin
                err_sticky <= 1'b1;
            end else if (cfg_clear) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
